// File: rtl/cluster_pe_nd.sv
// k-means cluster processing element: holds one centre, accumulates assigned points,
// computes the new mean with a restoring divider and flags stability against TOL.
module cluster_pe_nd #(
    parameter int DIM       = 3,
    parameter int DIM_W     = 8,
    parameter int MAX_N     = 1024,
    parameter int MAX_DEPTH = 16,
    parameter logic [DIM*DIM_W-1:0] INIT_CENTER = {(DIM*DIM_W){1'b0}},
    parameter logic [DIM_W-1:0]     TOL         = {DIM_W{1'b0}},
    localparam int CNT_W   = $clog2(MAX_N + 1),
    localparam int ACC_W   = DIM_W + CNT_W,
    localparam int DEPTH_W = $clog2(MAX_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   load_depth,
    input  logic [DEPTH_W-1:0]     depth_in,
    input  logic                   init,
    input  logic                   start_iter,
    input  logic                   accept,
    input  logic [DIM*DIM_W-1:0]   point_in,
    input  logic                   update_req,
    input  logic                   next_level,
    input  logic                   sorting,
    input  logic                   parent_switch,
    input  logic                   child_switch,
    input  logic [DIM*DIM_W-1:0]   parent_in,
    input  logic [DIM*DIM_W-1:0]   child_in,
    output logic [DIM*DIM_W-1:0]   center_out,
    output logic [DIM*DIM_W-1:0]   parent_out,
    output logic [DIM*DIM_W-1:0]   child_out,
    output logic [DEPTH_W-1:0]     child_depth,
    output logic                   ce_en,
    output logic                   busy,
    output logic                   done,
    output logic                   stable,
    output logic [CNT_W-1:0]       count,
    output logic                   overflow
);

    localparam int DIM_IW = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int BIT_W  = $clog2(ACC_W);
    localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_N);
    localparam logic [DIM_IW-1:0] LAST_DIM = DIM_IW'(DIM - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(ACC_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DIV   = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    state_t                 state_r;
    logic [DIM*DIM_W-1:0]   center_r;
    logic [DIM*DIM_W-1:0]   parent_out_r;
    logic [DIM*DIM_W-1:0]   child_out_r;
    logic [DIM_W-1:0]       new_r [DIM];
    logic [ACC_W-1:0]       acc_r [DIM];
    logic [CNT_W-1:0]       count_r;
    logic [DEPTH_W-1:0]     depth_r;
    logic [DEPTH_W-1:0]     ttl_r;
    logic                   busy_r;
    logic                   done_r;
    logic                   stable_r;
    logic                   ovf_r;
    logic [DIM_IW-1:0]      dim_r;
    logic [BIT_W-1:0]       bit_r;
    logic                   load_r;
    logic [ACC_W-1:0]       dvd_r;
    logic [CNT_W-1:0]       rem_r;

    logic [CNT_W:0]         trial_s;
    logic                   ge_s;
    logic [CNT_W:0]         diff_s;
    logic [CNT_W-1:0]       rem_next_s;
    logic [ACC_W-1:0]       quo_s;
    logic [DIM_IW-1:0]      dim_inc_s;
    logic [DIM*DIM_W-1:0]   new_flat_s;
    logic                   within_tol_s;

    function automatic logic [DIM_W-1:0] abs_diff(input logic [DIM_W-1:0] a,
                                                  input logic [DIM_W-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // One restoring-division step: quotient bits shift into the dividend register from the right.
    always_comb begin
        trial_s    = {rem_r, dvd_r[ACC_W-1]};
        ge_s       = (trial_s >= {1'b0, count_r});
        diff_s     = trial_s - {1'b0, count_r};
        rem_next_s = ge_s ? diff_s[CNT_W-1:0] : trial_s[CNT_W-1:0];
        quo_s      = {dvd_r[ACC_W-2:0], ge_s};
        dim_inc_s  = dim_r + DIM_IW'(1);
    end

    // Pack the new centre and compare it against the current one within TOL.
    always_comb begin
        new_flat_s   = {(DIM*DIM_W){1'b0}};
        within_tol_s = 1'b1;
        for (int d = 0; d < DIM; d++) begin
            new_flat_s[d*DIM_W +: DIM_W] = new_r[d];
            within_tol_s = within_tol_s &
                (abs_diff(new_r[d], center_r[d*DIM_W +: DIM_W]) <= TOL);
        end
    end

    // Control FSM, accumulators, divider datapath and tree-phase registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= S_IDLE;
            center_r     <= INIT_CENTER;
            parent_out_r <= {(DIM*DIM_W){1'b0}};
            child_out_r  <= {(DIM*DIM_W){1'b0}};
            for (int d = 0; d < DIM; d++) begin
                new_r[d] <= {DIM_W{1'b0}};
                acc_r[d] <= {ACC_W{1'b0}};
            end
            count_r  <= {CNT_W{1'b0}};
            depth_r  <= {DEPTH_W{1'b0}};
            ttl_r    <= {DEPTH_W{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            stable_r <= 1'b0;
            ovf_r    <= 1'b0;
            dim_r    <= {DIM_IW{1'b0}};
            bit_r    <= {BIT_W{1'b0}};
            load_r   <= 1'b0;
            dvd_r    <= {ACC_W{1'b0}};
            rem_r    <= {CNT_W{1'b0}};
        end else begin
            done_r <= 1'b0;
            if (en) begin
                if (load_depth) begin
                    depth_r <= depth_in;
                end
                if (next_level && (ttl_r != {DEPTH_W{1'b0}})) begin
                    ttl_r <= ttl_r - DEPTH_W'(1);
                end
                case (state_r)
                    S_IDLE: begin
                        if (update_req && (count_r != {CNT_W{1'b0}})) begin
                            state_r <= S_DIV;
                            busy_r  <= 1'b1;
                            load_r  <= 1'b1;
                            dim_r   <= {DIM_IW{1'b0}};
                        end else begin
                            if (update_req) begin
                                stable_r <= 1'b1;
                                done_r   <= 1'b1;
                            end
                            if (start_iter) begin
                                for (int d = 0; d < DIM; d++) begin
                                    acc_r[d] <= {ACC_W{1'b0}};
                                end
                                count_r <= {CNT_W{1'b0}};
                                ttl_r   <= depth_r;
                                ovf_r   <= 1'b0;
                            end else if (accept) begin
                                if (count_r == MAX_CNT) begin
                                    ovf_r <= 1'b1;
                                end else begin
                                    for (int d = 0; d < DIM; d++) begin
                                        acc_r[d] <= acc_r[d] + ACC_W'(point_in[d*DIM_W +: DIM_W]);
                                    end
                                    count_r <= count_r + CNT_W'(1);
                                end
                            end
                        end
                        // A parent swap outranks a child swap, and both outrank init.
                        if (sorting && parent_switch) begin
                            parent_out_r <= center_r;
                            center_r     <= parent_in;
                        end else if (sorting && child_switch) begin
                            child_out_r <= center_r;
                            center_r    <= child_in;
                        end else if (init) begin
                            center_r <= parent_in;
                        end
                    end
                    S_DIV: begin
                        if (accept) begin
                            ovf_r <= 1'b1;
                        end
                        if (load_r) begin
                            dvd_r  <= acc_r[0];
                            rem_r  <= {CNT_W{1'b0}};
                            bit_r  <= {BIT_W{1'b0}};
                            load_r <= 1'b0;
                        end else if (bit_r == LAST_BIT) begin
                            new_r[dim_r] <= quo_s[DIM_W-1:0];
                            if (dim_r == LAST_DIM) begin
                                state_r <= S_CHECK;
                            end else begin
                                dim_r <= dim_inc_s;
                                dvd_r <= acc_r[dim_inc_s];
                                rem_r <= {CNT_W{1'b0}};
                                bit_r <= {BIT_W{1'b0}};
                            end
                        end else begin
                            dvd_r <= quo_s;
                            rem_r <= rem_next_s;
                            bit_r <= bit_r + BIT_W'(1);
                        end
                    end
                    S_CHECK: begin
                        if (accept) begin
                            ovf_r <= 1'b1;
                        end
                        stable_r <= within_tol_s;
                        center_r <= new_flat_s;
                        for (int d = 0; d < DIM; d++) begin
                            acc_r[d] <= {ACC_W{1'b0}};
                        end
                        count_r <= {CNT_W{1'b0}};
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= S_IDLE;
                    end
                    default: begin
                        state_r <= S_IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign center_out  = center_r;
    assign parent_out  = parent_out_r;
    assign child_out   = child_out_r;
    assign child_depth = depth_r + DEPTH_W'(1);
    assign ce_en       = (ttl_r != {DEPTH_W{1'b0}});
    assign busy        = busy_r;
    assign done        = done_r;
    assign stable      = stable_r;
    assign count       = count_r;
    assign overflow    = ovf_r;

endmodule

// File: tb/tb_cluster_pe_nd.sv
// Directed bench for cluster_pe_nd: instance A at default sizing (TOL=1),
// instance B with MAX_N=4 and TOL=0; each is selected by its own enable.
module tb_cluster_pe_nd;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en_a, en_b;
    logic        load_depth, init, start_iter, accept, update_req, next_level;
    logic        sorting, parent_switch, child_switch;
    logic [3:0]  depth_in;
    logic [23:0] point_in, parent_in, child_in;

    logic [23:0] a_center, a_pout, a_cout, b_center, b_pout, b_cout;
    logic [3:0]  a_cdepth, b_cdepth;
    logic        a_ce, a_busy, a_done, a_stable, a_ovf;
    logic        b_ce, b_busy, b_done, b_stable, b_ovf;
    logic [10:0] a_count;
    logic [2:0]  b_count;

    int n_chk  = 0;
    int n_pass = 0;

    cluster_pe_nd #(.TOL(8'd1)) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .load_depth(load_depth), .depth_in(depth_in),
        .init(init), .start_iter(start_iter), .accept(accept), .point_in(point_in),
        .update_req(update_req), .next_level(next_level), .sorting(sorting),
        .parent_switch(parent_switch), .child_switch(child_switch),
        .parent_in(parent_in), .child_in(child_in), .center_out(a_center),
        .parent_out(a_pout), .child_out(a_cout), .child_depth(a_cdepth), .ce_en(a_ce),
        .busy(a_busy), .done(a_done), .stable(a_stable), .count(a_count), .overflow(a_ovf)
    );

    cluster_pe_nd #(.MAX_N(4), .TOL(8'd0)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .load_depth(load_depth), .depth_in(depth_in),
        .init(init), .start_iter(start_iter), .accept(accept), .point_in(point_in),
        .update_req(update_req), .next_level(next_level), .sorting(sorting),
        .parent_switch(parent_switch), .child_switch(child_switch),
        .parent_in(parent_in), .child_in(child_in), .center_out(b_center),
        .parent_out(b_pout), .child_out(b_cout), .child_depth(b_cdepth), .ce_en(b_ce),
        .busy(b_busy), .done(b_done), .stable(b_stable), .count(b_count), .overflow(b_ovf)
    );

    always #5 clk = ~clk;

    localparam logic [7:0] LD = 8'h80, INI = 8'h40, ST = 8'h20, ACC = 8'h10;
    localparam logic [7:0] NL = 8'h08, SRT = 8'h04, PSW = 8'h02, CSW = 8'h01;

    typedef struct {
        logic [7:0]  ctl;
        logic [3:0]  dep;
        logic [23:0] pt;
        logic [23:0] par;
        logic [23:0] chi;
        logic [23:0] e_center;
        logic [10:0] e_count;
        logic        e_ce;
        logic [23:0] e_pout;
        logic [23:0] e_cout;
        logic [3:0]  e_cdep;
    } vec_t;

    vec_t tbl [17];

    function automatic logic [23:0] pk(input int x0, input int x1, input int x2);
        logic [7:0] b0, b1, b2;
        b0 = x0[7:0];
        b1 = x1[7:0];
        b2 = x2[7:0];
        return {b2, b1, b0};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_ctl;
        load_depth = 1'b0; init = 1'b0; start_iter = 1'b0; accept = 1'b0;
        next_level = 1'b0; sorting = 1'b0; parent_switch = 1'b0; child_switch = 1'b0;
        update_req = 1'b0;
    endtask

    // Pulse update_req for one cycle and count edges until done, optionally freezing en.
    task automatic run_update(input bit on_b, input int exp_lat, input int frz_at,
                              input int frz_len, input string nm, output logic [23:0] pre_c);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        pre_c = 24'd0;
        update_req = 1'b1;
        tick();
        update_req = 1'b0;
        chk({nm, "_busy"}, on_b ? b_busy : a_busy, 32'd1);
        while (!seen && n < 200) begin
            if (n == frz_at) begin
                if (on_b) en_b = 1'b0; else en_a = 1'b0;
            end
            if (n == frz_at + frz_len) begin
                if (on_b) en_b = 1'b1; else en_a = 1'b1;
            end
            pre_c = on_b ? b_center : a_center;
            tick();
            n++;
            if (on_b ? b_done : a_done) seen = 1'b1;
        end
        if (on_b) en_b = 1'b1; else en_a = 1'b1;
        chk({nm, "_latency"}, n, exp_lat);
    endtask

    initial begin
        logic [23:0] pa, pb, pc, p356, p246, p468, p999, p111, pre_c;
        int ndone;
        pa   = pk(10, 20, 30);
        pb   = pk(40, 50, 60);
        pc   = pk(70, 80, 90);
        p356 = pk(3, 5, 6);
        p246 = pk(2, 4, 6);
        p468 = pk(4, 6, 8);
        p999 = pk(9, 9, 9);
        p111 = pk(1, 1, 1);

        //         ctl           dep   pt    par   chi   center count   ce    pout  cout  cdep
        tbl[0]  = '{LD,          4'd3, 24'd0, 24'd0, 24'd0, 24'd0, 11'd0, 1'b0, 24'd0, 24'd0, 4'd4};
        tbl[1]  = '{INI,         4'd0, 24'd0, pa,    24'd0, pa,    11'd0, 1'b0, 24'd0, 24'd0, 4'd4};
        tbl[2]  = '{SRT|PSW|CSW, 4'd0, 24'd0, pb,    pc,    pb,    11'd0, 1'b0, pa,    24'd0, 4'd4};
        tbl[3]  = '{SRT|CSW,     4'd0, 24'd0, pb,    pc,    pc,    11'd0, 1'b0, pa,    pb,    4'd4};
        tbl[4]  = '{PSW,         4'd0, 24'd0, pb,    24'd0, pc,    11'd0, 1'b0, pa,    pb,    4'd4};
        tbl[5]  = '{ST,          4'd0, 24'd0, 24'd0, 24'd0, pc,    11'd0, 1'b1, pa,    pb,    4'd4};
        tbl[6]  = '{NL,          4'd0, 24'd0, 24'd0, 24'd0, pc,    11'd0, 1'b1, pa,    pb,    4'd4};
        tbl[7]  = '{NL,          4'd0, 24'd0, 24'd0, 24'd0, pc,    11'd0, 1'b1, pa,    pb,    4'd4};
        tbl[8]  = '{NL,          4'd0, 24'd0, 24'd0, 24'd0, pc,    11'd0, 1'b0, pa,    pb,    4'd4};
        tbl[9]  = '{NL,          4'd0, 24'd0, 24'd0, 24'd0, pc,    11'd0, 1'b0, pa,    pb,    4'd4};
        tbl[10] = '{INI,         4'd0, 24'd0, p356,  24'd0, p356,  11'd0, 1'b0, pa,    pb,    4'd4};
        tbl[11] = '{ST,          4'd0, 24'd0, 24'd0, 24'd0, p356,  11'd0, 1'b1, pa,    pb,    4'd4};
        tbl[12] = '{ACC,         4'd0, p246,  24'd0, 24'd0, p356,  11'd1, 1'b1, pa,    pb,    4'd4};
        tbl[13] = '{ACC,         4'd0, p468,  24'd0, 24'd0, p356,  11'd2, 1'b1, pa,    pb,    4'd4};
        tbl[14] = '{ST|ACC,      4'd0, p999,  24'd0, 24'd0, p356,  11'd0, 1'b1, pa,    pb,    4'd4};
        tbl[15] = '{ACC,         4'd0, p246,  24'd0, 24'd0, p356,  11'd1, 1'b1, pa,    pb,    4'd4};
        tbl[16] = '{ACC,         4'd0, p468,  24'd0, 24'd0, p356,  11'd2, 1'b1, pa,    pb,    4'd4};

        clr_ctl();
        en_a = 1'b1; en_b = 1'b0;
        depth_in = 4'd0; point_in = 24'd0; parent_in = 24'd0; child_in = 24'd0;

        #2;
        chk("rst_center", a_center, 32'd0);
        chk("rst_count", a_count, 32'd0);
        chk("rst_busy", a_busy, 32'd0);
        chk("rst_done", a_done, 32'd0);
        chk("rst_stable", a_stable, 32'd0);
        chk("rst_ovf", a_ovf, 32'd0);
        chk("rst_ce", a_ce, 32'd0);
        chk("rst_pout", a_pout, 32'd0);
        chk("rst_cout", a_cout, 32'd0);
        chk("rst_cdepth", a_cdepth, 32'd1);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 17; i++) begin
            load_depth    = tbl[i].ctl[7];
            init          = tbl[i].ctl[6];
            start_iter    = tbl[i].ctl[5];
            accept        = tbl[i].ctl[4];
            next_level    = tbl[i].ctl[3];
            sorting       = tbl[i].ctl[2];
            parent_switch = tbl[i].ctl[1];
            child_switch  = tbl[i].ctl[0];
            depth_in      = tbl[i].dep;
            point_in      = tbl[i].pt;
            parent_in     = tbl[i].par;
            child_in      = tbl[i].chi;
            tick();
            clr_ctl();
            chk($sformatf("v%0d_center", i), a_center, tbl[i].e_center);
            chk($sformatf("v%0d_count", i), a_count, tbl[i].e_count);
            chk($sformatf("v%0d_ce", i), a_ce, tbl[i].e_ce);
            chk($sformatf("v%0d_pout", i), a_pout, tbl[i].e_pout);
            chk($sformatf("v%0d_cout", i), a_cout, tbl[i].e_cout);
            chk($sformatf("v%0d_cdepth", i), a_cdepth, tbl[i].e_cdep);
        end

        // Mean of (2,4,6),(4,6,8) from centre (3,5,6): (3,5,7), within TOL=1.
        run_update(1'b0, 59, -1, 0, "mean", pre_c);
        chk("mean_pre_center", pre_c, p356);
        chk("mean_center", a_center, pk(3, 5, 7));
        chk("mean_stable", a_stable, 32'd1);
        chk("mean_busy", a_busy, 32'd0);
        chk("mean_count", a_count, 32'd0);
        tick();
        chk("mean_done_pulse", a_done, 32'd0);

        // Instance B: truncation and instability with TOL=0.
        en_a = 1'b0; en_b = 1'b1;
        start_iter = 1'b1; tick(); clr_ctl();
        accept = 1'b1; point_in = pk(3, 0, 255); tick();
        point_in = pk(4, 1, 254); tick(); clr_ctl();
        chk("trunc_count", b_count, 32'd2);
        run_update(1'b1, 35, -1, 0, "trunc", pre_c);
        chk("trunc_center", b_center, pk(3, 0, 254));
        chk("trunc_stable", b_stable, 32'd0);
        tick();

        // Empty update: done one cycle after update_req, centre kept, stable set.
        start_iter = 1'b1; tick(); clr_ctl();
        update_req = 1'b1; tick(); clr_ctl();
        chk("empty_done", b_done, 32'd1);
        chk("empty_busy", b_busy, 32'd0);
        chk("empty_stable", b_stable, 32'd1);
        chk("empty_center", b_center, pk(3, 0, 254));
        tick();
        chk("empty_done_pulse", b_done, 32'd0);

        // Overflow at MAX_N=4, with en frozen for 5 cycles during the divide.
        start_iter = 1'b1; tick(); clr_ctl();
        accept = 1'b1; point_in = p111;
        for (int k = 0; k < 4; k++) tick();
        chk("ovf_count4", b_count, 32'd4);
        chk("ovf_flag_before", b_ovf, 32'd0);
        tick(); clr_ctl();
        chk("ovf_count_sat", b_count, 32'd4);
        chk("ovf_flag", b_ovf, 32'd1);
        run_update(1'b1, 40, 10, 5, "ovf", pre_c);
        chk("ovf_center", b_center, p111);
        chk("ovf_stable", b_stable, 32'd0);
        tick();
        start_iter = 1'b1; tick(); clr_ctl();
        chk("ovf_cleared", b_ovf, 32'd0);

        // Asynchronous reset in the middle of a division on instance A.
        en_a = 1'b1; en_b = 1'b0;
        start_iter = 1'b1; tick(); clr_ctl();
        accept = 1'b1; point_in = p246; tick(); clr_ctl();
        update_req = 1'b1; tick(); clr_ctl();
        for (int k = 0; k < 10; k++) tick();
        chk("mid_busy", a_busy, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_busy", a_busy, 32'd0);
        chk("arst_center", a_center, 32'd0);
        chk("arst_count", a_count, 32'd0);
        chk("arst_done", a_done, 32'd0);
        tick(); tick();
        @(negedge clk);
        rst = 1'b1;
        ndone = 0;
        for (int k = 0; k < 70; k++) begin
            tick();
            if (a_done) ndone++;
        end
        chk("arst_no_done", ndone, 32'd0);
        chk("arst_busy_after", a_busy, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
